cordic_dp: RTL and testbench

CORDIC_DP -- requirements
Module: cordic_dp

---
 rtl/cordic_dp.sv | 134 +++++++++++++
 tb/tb_cordic_dp.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_dp.sv
// CORDIC datapath: one micro-rotation per ld, rotation or vectoring mode.
// x/y kept in 18 bits to absorb the CORDIC gain; outputs saturate to 16 bits.
module cordic_dp (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               init,
    input  logic               ld,
    input  logic               mode,
    input  logic signed [15:0] x_in,
    input  logic signed [15:0] y_in,
    input  logic signed [15:0] z_in,
    output logic        [15:0] itr,
    output logic signed [15:0] x_out,
    output logic signed [15:0] y_out,
    output logic signed [15:0] z_out,
    output logic               busy,
    output logic               res_vld
);

    localparam int unsigned DW = 16;
    localparam int unsigned XW = 18;
    localparam int unsigned IW = 4;
    localparam logic [IW-1:0] ITR_LAST = IW'(15);

    logic signed [XW-1:0] x_q, y_q, x_d, y_d;
    logic signed [XW-1:0] x_shr, y_shr;
    logic        [DW-1:0] z_q, z_d;
    logic        [DW-1:0] atan_c;
    logic        [IW-1:0] itr_q, itr_d;
    logic                 mode_q, mode_d;
    logic                 busy_q, busy_d;
    logic                 vld_q, vld_d;
    logic                 d_pos;

    // arctan(2^-i) in binary-angle units (32768 = pi)
    always_comb begin
        atan_c = '0;
        case (itr_q)
            4'd0:  atan_c = 16'd8192;
            4'd1:  atan_c = 16'd4836;
            4'd2:  atan_c = 16'd2555;
            4'd3:  atan_c = 16'd1297;
            4'd4:  atan_c = 16'd651;
            4'd5:  atan_c = 16'd326;
            4'd6:  atan_c = 16'd163;
            4'd7:  atan_c = 16'd81;
            4'd8:  atan_c = 16'd41;
            4'd9:  atan_c = 16'd20;
            4'd10: atan_c = 16'd10;
            4'd11: atan_c = 16'd5;
            4'd12: atan_c = 16'd3;
            4'd13: atan_c = 16'd1;
            4'd14: atan_c = 16'd1;
            default: atan_c = 16'd0;
        endcase
    end

    // next-state: init loads, ld performs one micro-rotation, otherwise hold
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        z_d    = z_q;
        itr_d  = itr_q;
        mode_d = mode_q;
        busy_d = busy_q;
        vld_d  = vld_q;
        x_shr  = x_q >>> itr_q;
        y_shr  = y_q >>> itr_q;
        d_pos  = mode_q ? y_q[XW-1] : ~z_q[DW-1];

        if (init) begin
            x_d    = XW'(x_in);
            y_d    = XW'(y_in);
            z_d    = z_in;
            itr_d  = '0;
            mode_d = mode;
            busy_d = 1'b1;
            vld_d  = 1'b0;
        end else if (ld) begin
            if (d_pos) begin
                x_d = x_q - y_shr;
                y_d = y_q + x_shr;
                z_d = z_q - atan_c;
            end else begin
                x_d = x_q + y_shr;
                y_d = y_q - x_shr;
                z_d = z_q + atan_c;
            end
            if (itr_q == ITR_LAST) begin
                busy_d = 1'b0;
                vld_d  = 1'b1;
            end else begin
                itr_d = itr_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            itr_q  <= '0;
            mode_q <= 1'b0;
            busy_q <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            z_q    <= z_d;
            itr_q  <= itr_d;
            mode_q <= mode_d;
            busy_q <= busy_d;
            vld_q  <= vld_d;
        end
    end

    function automatic logic signed [DW-1:0] sat16(input logic signed [XW-1:0] v);
        if (v > 18'sd32767) begin
            return 16'sh7fff;
        end else if (v < -18'sd32768) begin
            return 16'sh8000;
        end
        return v[DW-1:0];
    endfunction

    assign x_out   = sat16(x_q);
    assign y_out   = sat16(y_q);
    assign z_out   = z_q;
    assign itr     = {12'd0, itr_q};
    assign busy    = busy_q;
    assign res_vld = vld_q;

endmodule

// File: tb/tb_cordic_dp.sv
// Scoreboard bench for cordic_dp: job-level CORDIC model feeds a queue,
// a monitor pops and compares whenever res_vld rises.
module tb_cordic_dp;

    typedef struct {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic signed [15:0] z;
    } res_t;

    localparam int ATAN [16] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81,
                                 41, 20, 10, 5, 3, 1, 1, 0};

    logic               clk = 1'b0;
    logic               rst_b, init, ld, mode;
    logic signed [15:0] x_in, y_in, z_in;
    logic        [15:0] itr;
    logic signed [15:0] x_out, y_out, z_out;
    logic               busy, res_vld;

    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];
    logic prev_vld = 1'b0;

    cordic_dp dut (
        .clk(clk), .rst_b(rst_b), .init(init), .ld(ld), .mode(mode),
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .itr(itr), .x_out(x_out), .y_out(y_out), .z_out(z_out),
        .busy(busy), .res_vld(res_vld)
    );

    always #5 clk = ~clk;

    function automatic logic signed [15:0] sat16(input int v);
        if (v > 32767) return 16'sh7fff;
        if (v < -32768) return 16'sh8000;
        return 16'(v);
    endfunction

    // Reference: n micro-rotations from freshly loaded operands (index caps at 15)
    function automatic res_t model(input logic m, input logic signed [15:0] xi,
                                   input logic signed [15:0] yi,
                                   input logic signed [15:0] zi, input int n);
        int x = int'(xi);
        int y = int'(yi);
        int z = int'(zi);
        int xs, ys, d, i;
        res_t r;
        for (int k = 0; k < n; k++) begin
            i  = (k > 15) ? 15 : k;
            d  = m ? ((y < 0) ? 1 : -1) : ((z >= 0) ? 1 : -1);
            xs = x >>> i;
            ys = y >>> i;
            x  = x - d * ys;
            y  = y + d * xs;
            z  = int'(shortint'(z - d * ATAN[i]));
        end
        r.x = sat16(x);
        r.y = sat16(y);
        r.z = 16'(z);
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_near(input string name, input int act, input int exp, input int tol);
        checks++;
        if (act > exp + tol || act < exp - tol) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d +/-%0d", name, act, exp, tol);
        end
    endtask

    // Monitor: compare on every rising edge of res_vld
    always @(negedge clk) begin
        res_t r;
        if (res_vld && !prev_vld) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_res_vld: got res_vld=1 expected no pending job");
            end else begin
                r = exp_q.pop_front();
                check("sb_x", int'(x_out), int'(r.x));
                check("sb_y", int'(y_out), int'(r.y));
                check("sb_z", int'(z_out), int'(r.z));
                check("sb_itr", int'(itr), 15);
                check("sb_busy", int'(busy), 0);
            end
        end
        prev_vld = res_vld;
    end

    task automatic tick(input logic i, input logic l);
        init = i;
        ld   = l;
        @(negedge clk);
    endtask

    task automatic start(input logic m, input logic signed [15:0] x,
                         input logic signed [15:0] y, input logic signed [15:0] z);
        mode = m;
        x_in = x;
        y_in = y;
        z_in = z;
        tick(1'b1, 1'b1);
        check("init_itr", int'(itr), 0);
        check("init_busy", int'(busy), 1);
        check("init_vld", int'(res_vld), 0);
        x_in = 16'(int'($urandom));
        y_in = 16'(int'($urandom));
        z_in = 16'(int'($urandom));
        mode = ~m;
    endtask

    task automatic run_job(input logic m, input logic signed [15:0] x,
                           input logic signed [15:0] y, input logic signed [15:0] z,
                           input bit gaps);
        exp_q.push_back(model(m, x, y, z, 16));
        start(m, x, y, z);
        for (int k = 0; k < 16; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                for (int g = 0; g < int'($urandom_range(1, 3)); g++) tick(1'b0, 1'b0);
            end
            tick(1'b0, 1'b1);
        end
        tick(1'b0, 1'b0);
    endtask

    initial begin
        res_t r;
        rst_b = 1'b0;
        init  = 1'b0;
        ld    = 1'b0;
        mode  = 1'b0;
        x_in  = 16'sd1234;
        y_in  = 16'sd567;
        z_in  = 16'sd89;
        @(negedge clk);
        @(negedge clk);
        check("rst_x", int'(x_out), 0);
        check("rst_z", int'(z_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_vld", int'(res_vld), 0);
        rst_b = 1'b1;
        @(negedge clk);

        // rotate 19898 by pi/4
        run_job(1'b0, 16'sd19898, 16'sd0, 16'sd8192, 1'b0);
        check_near("rot45_x", int'(x_out), 23170, 16);
        check_near("rot45_y", int'(y_out), 23170, 16);
        check_near("rot45_z", int'(z_out), 0, 2);
        check("rot45_itr", int'(itr), 15);
        check("rot45_vld", int'(res_vld), 1);

        // extra ld after completion still rotates at index 15, res_vld stays
        r = model(1'b0, 16'sd19898, 16'sd0, 16'sd8192, 17);
        tick(1'b0, 1'b1);
        check("extra_x", int'(x_out), int'(r.x));
        check("extra_y", int'(y_out), int'(r.y));
        check("extra_z", int'(z_out), int'(r.z));
        check("extra_itr", int'(itr), 15);
        check("extra_vld", int'(res_vld), 1);

        // vectoring (10000,10000)
        run_job(1'b1, 16'sd10000, 16'sd10000, 16'sd0, 1'b0);
        check_near("vec_z", int'(z_out), 8192, 4);
        check_near("vec_y", int'(y_out), 0, 4);
        check_near("vec_x", int'(x_out), 23290, 24);

        // saturation: gain pushes both components past full scale
        run_job(1'b0, 16'sd32767, 16'sd32767, 16'sd0, 1'b0);
        check("sat_x", int'(x_out), 32767);
        check("sat_y", int'(y_out), 32767);
        run_job(1'b0, 16'sd32767, 16'sd0, 16'sd0, 1'b0);
        check("sat1_x", int'(x_out), 32767);
        check_near("sat1_y", int'(y_out), 0, 16);
        run_job(1'b0, -16'sd32768, 16'sd0, 16'sd0, 1'b0);
        check("satn_x", int'(x_out), -32768);

        // asynchronous reset mid-job at itr=7
        start(1'b0, 16'sd12000, -16'sd7000, 16'sd3000);
        for (int k = 0; k < 7; k++) tick(1'b0, 1'b1);
        check("pre_rst_itr", int'(itr), 7);
        #2 rst_b = 1'b0;
        #1;
        check("arst_x", int'(x_out), 0);
        check("arst_y", int'(y_out), 0);
        check("arst_z", int'(z_out), 0);
        check("arst_itr", int'(itr), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_vld", int'(res_vld), 0);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        run_job(1'b0, 16'sd12000, -16'sd7000, 16'sd3000, 1'b0);

        // ld gap of 3 cycles: registers hold the 5-iteration state
        exp_q.push_back(model(1'b1, 16'sd20000, -16'sd9000, 16'sd0, 16));
        start(1'b1, 16'sd20000, -16'sd9000, 16'sd0);
        for (int k = 0; k < 5; k++) tick(1'b0, 1'b1);
        r = model(1'b1, 16'sd20000, -16'sd9000, 16'sd0, 5);
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b0);
        check("gap_x", int'(x_out), int'(r.x));
        check("gap_y", int'(y_out), int'(r.y));
        check("gap_z", int'(z_out), int'(r.z));
        check("gap_itr", int'(itr), 5);
        for (int k = 5; k < 16; k++) tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);

        // init reasserted at itr=9 restarts with new operands
        start(1'b0, 16'sd5000, 16'sd5000, -16'sd6000);
        for (int k = 0; k < 9; k++) tick(1'b0, 1'b1);
        check("pre_reinit_itr", int'(itr), 9);
        exp_q.push_back(model(1'b0, -16'sd15000, 16'sd4000, 16'sd20000, 16));
        start(1'b0, -16'sd15000, 16'sd4000, 16'sd20000);
        check("reinit_x", int'(x_out), -15000);
        check("reinit_z", int'(z_out), 20000);
        for (int k = 0; k < 15; k++) tick(1'b0, 1'b1);
        check("reinit_vld15", int'(res_vld), 0);
        check("reinit_busy15", int'(busy), 1);
        tick(1'b0, 1'b1);
        check("reinit_vld16", int'(res_vld), 1);
        tick(1'b0, 1'b0);

        // randomized jobs with random ld gaps
        for (int j = 0; j < 24; j++) begin
            run_job(1'($urandom), 16'(int'($urandom)), 16'(int'($urandom)),
                    16'(int'($urandom)), 1'b1);
        end

        repeat (2) @(negedge clk);
        check("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
